// File: rtl/alu_wb_stage_if.sv
// Handshake bundle between the ALU, the writeback stage and the readout FIFO consumer.
// The slave side is the writeback stage. The master side is the ALU plus the downstream reader.
interface alu_wb_stage_if #(
  parameter int WIDTH = 4
);
  // ALU -> stage
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_result;
  logic             in_zero;
  logic             in_carry;
  logic             in_overflow;
  logic             in_flag;

  // stage -> readout consumer
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic [2:0]       out_op;

  modport slave (
    input  in_valid, in_op, in_result, in_zero, in_carry, in_overflow, in_flag,
    output in_ready,
    output out_valid, out_result, out_flags, out_op,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_result, in_zero, in_carry, in_overflow, in_flag,
    input  in_ready,
    input  out_valid, out_result, out_flags, out_op,
    output out_ready
  );
endinterface

// File: rtl/alu_wb_stage.sv
// ALU writeback stage. It captures each accepted ALU result into the accumulator and the
// last-flags register, tracks sticky add/sub overflow, and queues {op, result, flags} in a
// small FIFO for the readout logic.
module alu_wb_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_wb_stage_if.slave            bus,
  output logic [WIDTH-1:0]         acc_out,
  output logic [3:0]               flags_out,
  output logic                     sticky_ovf,
  input  logic                     clr_sticky,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_result [DEPTH];
  logic [3:0]       mem_flags  [DEPTH];
  logic [2:0]       mem_op     [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [3:0]    in_flags;
  logic          writes_acc;
  logic          ovf_set;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // in_ready depends only on registered occupancy, so there is no path from in_valid.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;

  assign push = bus.in_valid && !full;
  assign pop  = bus.out_ready && !empty;

  assign in_flags   = {bus.in_flag, bus.in_overflow, bus.in_carry, bus.in_zero};
  // Compare opcodes (110/111) only report flags and leave the accumulator alone.
  assign writes_acc = !(bus.in_op[2] && bus.in_op[1]);
  assign ovf_set    = push && bus.in_overflow && (bus.in_op[2:1] == 2'b00);

  assign bus.out_result = mem_result[rd_ptr];
  assign bus.out_flags  = mem_flags[rd_ptr];
  assign bus.out_op     = mem_op[rd_ptr];

  // Accumulator, last flags and sticky overflow. A set beats a clear on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out    <= '0;
      flags_out  <= '0;
      sticky_ovf <= 1'b0;
    end else begin
      if (push) begin
        flags_out <= in_flags;
        if (writes_acc) acc_out <= bus.in_result;
      end
      if (ovf_set)         sticky_ovf <= 1'b1;
      else if (clr_sticky) sticky_ovf <= 1'b0;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage. It is not reset because only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= bus.in_result;
      mem_flags[wr_ptr]  <= in_flags;
      mem_op[wr_ptr]     <= bus.in_op;
    end
  end
endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage. Each scenario task drives its own stimulus and checks results inline.
module tb_alu_wb_stage;
  logic       clk;
  logic       rst;
  logic       clr_sticky;
  logic [3:0] acc_out;
  logic [3:0] flags_out;
  logic       sticky_ovf;
  logic [2:0] count;

  int errors;
  int checks;

  alu_wb_stage_if #(.WIDTH(4)) bus ();

  alu_wb_stage #(.WIDTH(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .acc_out    (acc_out),
    .flags_out  (flags_out),
    .sticky_ovf (sticky_ovf),
    .clr_sticky (clr_sticky),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] op, input logic [3:0] res,
                        input logic z, input logic c, input logic o, input logic f);
    bus.in_valid    = v;
    bus.in_op       = op;
    bus.in_result   = res;
    bus.in_zero     = z;
    bus.in_carry    = c;
    bus.in_overflow = o;
    bus.in_flag     = f;
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] res,
                      input logic z, input logic c, input logic o, input logic f);
    set_in(1'b1, op, res, z, c, o, f);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    set_in(1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    clr_sticky    = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (acc_out !== 4'h0) begin errors++; $display("FAIL reset_acc got=%h exp=0", acc_out); end
    checks++; if (flags_out !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", flags_out); end
    checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b exp=0", sticky_ovf); end
  endtask

  task automatic test_accumulate();
    do_reset();
    push(3'b000, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (acc_out !== 4'h7) begin errors++; $display("FAIL acc_first got=%h exp=7", acc_out); end
    checks++; if (flags_out !== 4'b0000) begin errors++; $display("FAIL flags_first got=%b exp=0000", flags_out); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_result !== 4'h7) begin errors++; $display("FAIL latency_result got=%h exp=7", bus.out_result); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL first_count got=%0d exp=1", count); end
    push(3'b101, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (acc_out !== 4'hA) begin errors++; $display("FAIL acc_xor got=%h exp=a", acc_out); end
    checks++; if (flags_out !== 4'b0010) begin errors++; $display("FAIL flags_carry got=%b exp=0010", flags_out); end
    checks++; if (bus.out_result !== 4'h7) begin errors++; $display("FAIL head_kept got=%h exp=7", bus.out_result); end
  endtask

  task automatic test_sticky();
    do_reset();
    bus.out_ready = 1'b1;
    push(3'b000, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_set got=%b exp=1", sticky_ovf); end
    checks++; if (flags_out !== 4'b0100) begin errors++; $display("FAIL flags_ovf got=%b exp=0100", flags_out); end
    push(3'b011, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_hold got=%b exp=1", sticky_ovf); end
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL sticky_clear got=%b exp=0", sticky_ovf); end
    push(3'b011, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL sticky_and_noset got=%b exp=0", sticky_ovf); end
    push(3'b001, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_sub_set got=%b exp=1", sticky_ovf); end
    clr_sticky = 1'b1;
    push(3'b000, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0);
    clr_sticky = 1'b0;
    checks++; if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got=%b exp=1", sticky_ovf); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_compare();
    do_reset();
    push(3'b000, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'b110, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (acc_out !== 4'h5) begin errors++; $display("FAIL cmp_acc_hold got=%h exp=5", acc_out); end
    checks++; if (flags_out !== 4'b1000) begin errors++; $display("FAIL cmp_flags got=%b exp=1000", flags_out); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_op !== 3'b110) begin errors++; $display("FAIL cmp_entry_op got=%b exp=110", bus.out_op); end
    checks++; if (bus.out_result !== 4'h3) begin errors++; $display("FAIL cmp_entry_result got=%h exp=3", bus.out_result); end
    checks++; if (bus.out_flags !== 4'b1000) begin errors++; $display("FAIL cmp_entry_flags got=%b exp=1000", bus.out_flags); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL cmp_count got=%0d exp=1", count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 4; i++) push(3'b000, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
    push(3'b000, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL drop_count got=%0d exp=4", count); end
    checks++; if (acc_out !== 4'h4) begin errors++; $display("FAIL drop_acc got=%h exp=4", acc_out); end
    checks++; if (flags_out !== 4'b0000) begin errors++; $display("FAIL drop_flags got=%b exp=0000", flags_out); end
    checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL drop_sticky got=%b exp=0", sticky_ovf); end
    // in_valid stays high while full so a push-through on full would be visible.
    bus.in_valid  = 1'b1;
    bus.in_result = 4'hE;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL no_pushthrough_count got=%0d exp=3", count); end
    checks++; if (bus.out_result !== 4'h2) begin errors++; $display("FAIL drain_1 got=%h exp=2", bus.out_result); end
    for (int i = 3; i <= 4; i++) begin
      tick();
      checks++; if (bus.out_result !== 4'(i)) begin errors++; $display("FAIL drain_%0d got=%h exp=%h", i - 1, bus.out_result, 4'(i)); end
    end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drained_count got=%0d exp=0", count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drained_valid got=%b exp=0", bus.out_valid); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL pop_empty_count got=%0d exp=0", count); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 3'b100, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count_%0d got=%0d exp=1", i, count); end
      checks++; if (bus.out_result !== 4'(i)) begin errors++; $display("FAIL stream_data_%0d got=%h exp=%h", i, bus.out_result, 4'(i)); end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_end_count got=%0d exp=0", count); end
    checks++; if (acc_out !== 4'h9) begin errors++; $display("FAIL stream_acc got=%h exp=9", acc_out); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(3'b000, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0);
    push(3'b010, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'b010, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_rst_count got=%0d exp=3", count); end
    // rst and a valid input on the same edge: reset must win.
    set_in(1'b1, 3'b000, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", bus.out_valid); end
    checks++; if (acc_out !== 4'h0) begin errors++; $display("FAIL rst_mid_acc got=%h exp=0", acc_out); end
    checks++; if (flags_out !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags got=%b exp=0000", flags_out); end
    checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL rst_mid_sticky got=%b exp=0", sticky_ovf); end
    push(3'b010, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL post_rst_count got=%0d exp=1", count); end
    checks++; if (bus.out_result !== 4'h6) begin errors++; $display("FAIL post_rst_result got=%h exp=6", bus.out_result); end
    checks++; if (bus.out_op !== 3'b010) begin errors++; $display("FAIL post_rst_op got=%b exp=010", bus.out_op); end
    checks++; if (bus.out_flags !== 4'b0001) begin errors++; $display("FAIL post_rst_flags got=%b exp=0001", bus.out_flags); end
    checks++; if (acc_out !== 4'h6) begin errors++; $display("FAIL post_rst_acc got=%h exp=6", acc_out); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    clr_sticky = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_accumulate();
    test_sticky();
    test_compare();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Writeback stage directly downstream of the 4-bit ALU. It captures each ALU result and its flags through a valid/ready handshake.
- It maintains an accumulator that is fed back to the ALU as operand a, plus a last-flags register and a sticky overflow bit.
- It buffers results in a small FIFO for the display/readout logic further downstream.

Parameters:
- WIDTH, 4, data width of ALU result and accumulator.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  ALU output qualifies a result this cycle.
- in_ready  output  1  stage can accept; equals !full.
- in_op  input  3  ALU opcode that produced the result (000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110/111 compare).
- in_result  input  WIDTH  ALU result.
- in_zero, in_carry, in_overflow, in_flag  input  1 each  ALU flags.
- acc_out  output  WIDTH  accumulator; fed back as ALU operand a.
- flags_out  output  4  last accepted flags, packed {flag, overflow, carry, zero}.
- sticky_ovf  output  1  set on any accepted add/sub overflow.
- clr_sticky  input  1  clears sticky_ovf.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer takes the head entry.
- out_result  output  WIDTH  FIFO head result.
- out_flags  output  4  FIFO head flags, packed as flags_out.
- out_op  output  3  FIFO head opcode.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is synchronous. On a clk edge with rst=1, all registers clear:
  - acc_out=0, flags_out=0, sticky_ovf=0.
  - count=0, out_valid=0, and read/write pointers=0.
  - FIFO storage need not clear.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all buffered entries. rst has priority over every other event.
- Accept event: in_valid && in_ready at a clk edge. When in_ready=0, in_valid is ignored and nothing updates.
- On accept:
  - flags_out <= {in_flag, in_overflow, in_carry, in_zero}.
  - acc_out <= in_result if in_op is 000..101. For in_op 110/111 (compare) acc_out holds; only flags update.
  - The entry {in_op, in_result, flags} is written at the write pointer, and the write pointer advances modulo DEPTH.
- Sticky overflow:
  - Set on accept when in_overflow=1 and in_op is 000 or 001.
  - Cleared on an edge where clr_sticky=1 and there is no set event that edge.
  - Set wins when set and clear occur on the same edge.
- Pop event: out_valid && out_ready at a clk edge. The read pointer advances modulo DEPTH.
- out_result, out_flags and out_op are driven combinationally from the entry at the read pointer. They are valid whenever out_valid=1 and don't-care otherwise.
- Latency: an entry accepted at edge N gives out_valid=1 after edge N when the FIFO was empty, with its data on the outputs in that same cycle. There is no bypass of the empty FIFO within the cycle.
- Occupancy:
  - count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - full = (count==DEPTH); empty = (count==0); out_valid = !empty.
- Boundaries:
  - When full, in_ready=0 even if out_ready=1 that cycle, so there is no push-through on full.
  - Simultaneous push and pop when empty cannot happen, because out_valid=0.
  - Pointers wrap from DEPTH-1 to 0. Order is strictly FIFO across the wrap.
  - A pop while empty is ignored.
- acc_out and flags_out are independent of FIFO draining. They reflect the most recent accept even while the FIFO is full or empty.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
1. Reset, then push op=000, result=4'h7, overflow=0 with out_ready=0:
   - acc_out=7 and flags_out=0000 after the edge.
   - out_valid=1, out_result=7, count=1.
2. Push op=000, result=4'h8, carry=0, overflow=1:
   - sticky_ovf=1 and flags_out=0100.
   - A following push with op=011 and overflow=1 leaves sticky_ovf at 1.
   - Pulsing clr_sticky alone clears it to 0.
   - clr_sticky asserted on the same edge as an add-overflow accept leaves sticky_ovf=1.
3. Push op=110, result=4'h3, flag=1 after acc=5:
   - acc_out stays 5; flags_out=1000.
   - The FIFO entry holds op=110, result=3.
4. With out_ready=0, push 4 entries (results 1,2,3,4):
   - count=4 and in_ready=0.
   - A fifth in_valid with result 9 is dropped.
   - Asserting out_ready then drains 1,2,3,4 in order, and count returns to 0.
5. Steady stream with in_valid=1 and out_ready=1 for 10 cycles, results 0..9:
   - count stays at 1 after the first cycle.
   - Outputs read 0..9 in order across pointer wrap.
6. Fill 3 entries, then assert rst for one cycle:
   - count=0, out_valid=0, acc_out=0, flags_out=0, sticky_ovf=0.
   - The next push appears as the sole head entry.
